// File: rtl/color_blob_tracker.sv
// Colour blob tracker for a 320x240 RGB565 pixel stream.
// Counts the pixels that fall inside a colour window and sums their
// coordinates. At each frame end it reports the match count and the
// centroid. The centroid comes from a 26-cycle restoring divider that
// runs while the next frame is being accumulated.
module color_blob_tracker #(
  parameter logic [4:0]  R_MIN      = 5'd20,
  parameter logic [5:0]  G_MAX      = 6'd24,
  parameter logic [4:0]  B_MAX      = 5'd12,
  parameter logic [16:0] MIN_PIXELS = 17'd64
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        pix_we,
  input  logic [15:0] pix_data,
  output logic        res_valid,
  output logic        res_found,
  output logic [8:0]  res_x,
  output logic [7:0]  res_y,
  output logic [16:0] res_count,
  output logic        res_overrun
);

  localparam logic [8:0] X_LAST  = 9'd319;
  localparam logic [7:0] Y_LAST  = 8'd239;
  localparam logic [4:0] IT_LAST = 5'd25;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  // ---------------------------------------------------------------------
  // Input alignment and frame-end detection
  // ---------------------------------------------------------------------
  logic we_q, vs_q, vs_prev_q, armed_q;
  logic fe;

  // pix_data trails pix_we by one cycle, so the strobe is delayed to line up with it
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      we_q      <= pix_we;
      vs_q      <= vsync;
      vs_prev_q <= vs_q;
      // first blanking interval after reset marks the start of a whole frame
      if (vs_q) armed_q <= 1'b1;
    end
  end

  assign fe = vs_q & ~vs_prev_q;

  // ---------------------------------------------------------------------
  // Raster position
  // ---------------------------------------------------------------------
  logic [8:0] x_q;
  logic [7:0] y_q;
  logic       full_q;

  // raster scan position; it freezes at the last pixel of the frame until blanking
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      full_q <= 1'b0;
    end else if (vs_q) begin
      x_q    <= '0;
      y_q    <= '0;
      full_q <= 1'b0;
    end else if (we_q && !full_q) begin
      if (x_q == X_LAST) begin
        if (y_q == Y_LAST) begin
          full_q <= 1'b1;
        end else begin
          x_q <= '0;
          y_q <= y_q + 8'd1;
        end
      end else begin
        x_q <= x_q + 9'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Colour match and accumulation
  // ---------------------------------------------------------------------
  logic        pix_match, take;
  logic [16:0] cnt_q, cnt_d;
  logic [25:0] sx_q, sx_d;
  logic [24:0] sy_q, sy_d;

  assign pix_match = (pix_data[15:11] >= R_MIN) &&
                     (pix_data[10:5]  <= G_MAX) &&
                     (pix_data[4:0]   <= B_MAX);

  // Pixels during blanking are dropped. A pixel that lands exactly on the
  // frame-end cycle still belongs to the closing frame.
  assign take = we_q & ~full_q & armed_q & (~vs_q | fe) & pix_match;

  // sums including the current pixel, which feed both the registers and the snapshot
  always_comb begin
    cnt_d = cnt_q + {16'd0, take};
    sx_d  = sx_q + (take ? {17'd0, x_q} : 26'd0);
    sy_d  = sy_q + (take ? {17'd0, y_q} : 25'd0);
  end

  // per-frame accumulators, cleared at frame end once the snapshot has been taken
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else if (fe) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else if (take) begin
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Divider control
  // ---------------------------------------------------------------------
  state_t state_q, state_d;
  logic [4:0] it_q;

  // divider state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state: a frame end is accepted only when idle; busy frame ends are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fe && armed_q)    state_d = S_DIV;
      S_DIV:   if (it_q == IT_LAST)  state_d = S_DONE;
      S_DONE:                        state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Shared-counter restoring dividers (x and y in lock step)
  // ---------------------------------------------------------------------
  logic [25:0] dvx_q, dvy_q, dvx_n, dvy_n;
  logic [16:0] remx_q, remy_q, remx_n, remy_n;
  logic [17:0] shx, shy, difx, dify;
  logic [16:0] divisor_q, snap_cnt_q;
  logic        snap_found_q, cnt_ok;

  // The remainder stays below the divisor, so the shifted value is below twice
  // the divisor. Bit 17 of the difference is therefore the borrow of the trial
  // subtraction.
  always_comb begin
    shx    = {remx_q, dvx_q[25]};
    shy    = {remy_q, dvy_q[25]};
    difx   = shx - {1'b0, divisor_q};
    dify   = shy - {1'b0, divisor_q};
    remx_n = difx[17] ? shx[16:0] : difx[16:0];
    remy_n = dify[17] ? shy[16:0] : dify[16:0];
    dvx_n  = {dvx_q[24:0], ~difx[17]};
    dvy_n  = {dvy_q[24:0], ~dify[17]};
  end

  // a count below threshold divides by 1 and its centroid is discarded
  assign cnt_ok = (cnt_d >= MIN_PIXELS);

  // ---------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------
  logic        valid_q, found_q, ovr_q;
  logic [8:0]  rx_q;
  logic [7:0]  ry_q;
  logic [16:0] rcnt_q;

  // snapshot on accepted frame end, iterate in DIV, publish in DONE
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dvx_q        <= '0;
      dvy_q        <= '0;
      remx_q       <= '0;
      remy_q       <= '0;
      it_q         <= '0;
      divisor_q    <= '0;
      snap_cnt_q   <= '0;
      snap_found_q <= 1'b0;
      valid_q      <= 1'b0;
      found_q      <= 1'b0;
      rx_q         <= '0;
      ry_q         <= '0;
      rcnt_q       <= '0;
      ovr_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (fe && armed_q) begin
          dvx_q        <= sx_d;
          dvy_q        <= {1'b0, sy_d};
          remx_q       <= '0;
          remy_q       <= '0;
          it_q         <= '0;
          snap_cnt_q   <= cnt_d;
          snap_found_q <= cnt_ok;
          divisor_q    <= cnt_ok ? cnt_d : 17'd1;
        end
        S_DIV: begin
          dvx_q  <= dvx_n;
          dvy_q  <= dvy_n;
          remx_q <= remx_n;
          remy_q <= remy_n;
          it_q   <= it_q + 5'd1;
        end
        S_DONE: begin
          valid_q <= 1'b1;
          found_q <= snap_found_q;
          rcnt_q  <= snap_cnt_q;
          rx_q    <= snap_found_q ? dvx_q[8:0] : 9'd0;
          ry_q    <= snap_found_q ? dvy_q[7:0] : 8'd0;
        end
        default: ;
      endcase
      // a frame end while busy loses its snapshot; flag it until reset
      if (fe && state_q != S_IDLE) ovr_q <= 1'b1;
    end
  end

  assign res_valid   = valid_q;
  assign res_found   = found_q;
  assign res_x       = rx_q;
  assign res_y       = ry_q;
  assign res_count   = rcnt_q;
  assign res_overrun = ovr_q;

endmodule

// File: tb/tb_color_blob_tracker.sv
// Directed bench for color_blob_tracker: each stimulus frame pushes its
// hand-computed result, and a monitor pops and checks it on res_valid.
module tb_color_blob_tracker;

  localparam logic [15:0] RED  = 16'hF800;
  localparam logic [15:0] GRN  = 16'h07E0;
  localparam logic [15:0] EDGE = {5'd20, 6'd24, 5'd12};
  localparam logic [15:0] NR   = {5'd19, 6'd0,  5'd0};
  localparam logic [15:0] NG   = {5'd31, 6'd25, 5'd0};
  localparam logic [15:0] NB   = {5'd31, 6'd0,  5'd13};

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        pix_we = 1'b0;
  logic [15:0] pix_data = '0;
  logic        res_valid, res_found, res_overrun;
  logic [8:0]  res_x;
  logic [7:0]  res_y;
  logic [16:0] res_count;

  color_blob_tracker dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .pix_we(pix_we),
    .pix_data(pix_data), .res_valid(res_valid), .res_found(res_found),
    .res_x(res_x), .res_y(res_y), .res_count(res_count),
    .res_overrun(res_overrun)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int cnt; int found; int x; int y; int ov;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] pend = '0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // pix_data lags pix_we by one cycle, so each step shows the previous step's data
  task automatic step(input logic we, input logic [15:0] d, input logic vs);
    @(negedge pclk);
    pix_we   = we;
    pix_data = pend;
    pend     = d;
    vsync    = vs;
  endtask

  // called right after the step that raises vsync; the FE cycle follows the next edge
  task automatic push(input int cn, input int f, input int x, input int y, input int ov);
    exp_t e;
    e.cyc = cyc + 29;
    e.cnt = cn; e.found = f; e.x = x; e.y = y; e.ov = ov;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, GRN, vsync);
    chk("drain_timeout", q.size(), 0);
    repeat (2) step(1'b0, GRN, vsync);
  endtask

  task automatic frame_end();
    repeat (3) step(1'b0, GRN, 1'b1);
  endtask

  // scoreboard monitor
  always @(negedge pclk) begin : mon
    exp_t e;
    if (rst_n && res_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("res_latency_cycle", cyc, e.cyc);
        chk("res_count", res_count, e.cnt);
        chk("res_found", res_found, e.found);
        chk("res_x", res_x, e.x);
        chk("res_y", res_y, e.y);
        chk("res_overrun", res_overrun, e.ov);
      end
    end
  end

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_found", res_found, 0);
    chk("rst_x", res_x, 0);
    chk("rst_overrun", res_overrun, 0);
    rst_n = 1'b1;

    // partial first frame with a reset in the middle: never reported
    for (int i = 0; i < 30; i++) step(1'b1, RED, 1'b0);
    rst_n = 1'b0;
    repeat (3) step(1'b0, GRN, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, RED, 1'b0);
    step(1'b0, GRN, 1'b1);
    frame_end();
    // first whole frame: all green
    for (int i = 0; i < 20; i++) step(1'b1, GRN, 1'b0);
    step(1'b0, GRN, 1'b1);
    push(0, 0, 0, 0, 0);
    frame_end();
    drain();

    // 63 matches (threshold-edge colours mixed in), gaps carry red data that must be ignored
    for (int i = 0; i < 100; i++) begin
      step(1'b1, (i < 63) ? ((i % 2) ? EDGE : RED)
                          : ((i % 3 == 0) ? NR : ((i % 3 == 1) ? NG : NB)), 1'b0);
      step(1'b0, RED, 1'b0);
    end
    step(1'b0, GRN, 1'b1);
    push(63, 0, 0, 0, 0);
    frame_end();
    drain();

    // exactly 64 matches at x 36..99; the last strobe is one cycle before vsync rises
    for (int i = 0; i < 100; i++) step(1'b1, (i >= 36) ? RED : GRN, 1'b0);
    step(1'b0, GRN, 1'b1);
    push(64, 1, 67, 0, 0);
    frame_end();
    drain();

    // 10x10 red square at x 100..109, y 2..11
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 320; x++)
        step(1'b1, (y >= 2 && x >= 100 && x <= 109) ? RED : GRN, 1'b0);
    step(1'b0, GRN, 1'b1);
    push(100, 1, 104, 6, 0);
    frame_end();
    drain();

    // reset while dividing: no pulse, stale result cleared
    for (int i = 0; i < 64; i++) step(1'b1, RED, 1'b0);
    step(1'b0, GRN, 1'b1);
    repeat (10) step(1'b0, GRN, 1'b1);
    rst_n = 1'b0;
    repeat (3) step(1'b0, GRN, 1'b1);
    chk("abort_valid_in_reset", res_valid, 0);
    rst_n = 1'b1;
    repeat (40) step(1'b0, GRN, 1'b1);
    chk("abort_count", res_count, 0);
    chk("abort_found", res_found, 0);

    // second frame end 10 cycles after the first: dropped, overrun flagged
    for (int i = 0; i < 64; i++) step(1'b1, RED, 1'b0);
    step(1'b0, GRN, 1'b1);
    push(64, 1, 31, 0, 1);
    repeat (9) step(1'b1, GRN, 1'b0);
    step(1'b0, GRN, 1'b1);
    frame_end();
    drain();
    chk("overrun_sticky", res_overrun, 1);

    // full red frame plus 5 extra strobes that must be ignored
    for (int i = 0; i < 76805; i++) step(1'b1, RED, 1'b0);
    step(1'b0, GRN, 1'b1);
    push(76800, 1, 159, 119, 1);
    frame_end();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/color_blob_tracker.md
COLOR_BLOB_TRACKER -- requirements
Module: color_blob_tracker

Interface
REQ-001 Parameter R_MIN, default 5'd20: minimum red component (RGB565 bits 15:11) for a target pixel.
REQ-002 Parameter G_MAX, default 6'd24: maximum green component (bits 10:5) for a target pixel.
REQ-003 Parameter B_MAX, default 5'd12: maximum blue component (bits 4:0) for a target pixel.
REQ-004 Parameter MIN_PIXELS, default 17'd64, range 1..76800: minimum match count for a valid blob.
REQ-005 pclk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 vsync  in  1  camera vsync; high = vertical blanking.
REQ-008 pix_we  in  1  pixel strobe from the capture stage.
REQ-009 pix_data  in  16  RGB565 pixel; valid in the cycle after pix_we is high.
REQ-010 res_valid  out  1  one-cycle result pulse.
REQ-011 res_found  out  1  match count >= MIN_PIXELS for the reported frame.
REQ-012 res_x  out  9  centroid column, 0..319.
REQ-013 res_y  out  8  centroid row, 0..239.
REQ-014 res_count  out  17  matched pixel count for the reported frame.
REQ-015 res_overrun  out  1  sticky: a frame end arrived while the divider was busy.

Function
REQ-016 The block shall register pix_we once (we_d); a pixel shall be qualified only when we_d=1, sampling pix_data in that cycle.
REQ-017 The block shall register vsync once (vs_d); frame end (FE) shall be the cycle in which vs_d=1 and its previous value was 0.
REQ-018 Column counter x (9b) and row counter y (8b) shall clear while vs_d=1, advance on each qualified pixel, wrap x 319->0 with y+1, and saturate at the 76800th pixel.
REQ-019 Qualified pixels beyond index 76799 shall be ignored.
REQ-020 A pixel shall match when R>=R_MIN and G<=G_MAX and B<=B_MAX, compared unsigned.
REQ-021 Accumulators shall be cnt (17b), sum_x (26b), and sum_y (25b), adding 1, x, and y per matched pixel, with no overflow possible at full frame.
REQ-022 After reset, accumulation shall stay disarmed until the first cycle with vs_d=1, so a partial first frame is never reported.
REQ-023 At FE the block shall snapshot the accumulators, including any pixel qualified in that same cycle, and clear them for the next frame.
REQ-024 Accumulation of the next frame shall continue in parallel with the divider.
REQ-025 Divider FSM states: IDLE, DIV, DONE; IDLE->DIV on an armed FE; DIV->DONE after exactly 26 cycles; DONE->IDLE after 1 cycle.
REQ-026 DIV shall compute sum_x/cnt and sum_y/cnt by shared-counter restoring division, 1 quotient bit per cycle, truncating.
REQ-027 When the snapshot cnt < MIN_PIXELS, DIV shall still take 26 cycles, with res_found=0, res_x=0, res_y=0, and no division by zero.
REQ-028 In DONE, res_valid shall be 1 for exactly one cycle, 28 pclk cycles after the FE cycle.
REQ-029 In DONE, res_found, res_x, res_y, and res_count shall update and then hold until the next DONE.
REQ-030 An FE occurring while the FSM is in DIV or DONE shall discard that frame's snapshot, set res_overrun, and leave the in-flight result unaffected.

Reset
REQ-031 rst_n=0 shall asynchronously clear all outputs, accumulators, counters, we_d, vs_d, and the armed flag to 0, and force the FSM to IDLE.
REQ-032 Reset asserted mid-DIV shall abort the division with no res_valid pulse.
REQ-033 After reset release, the block shall operate normally from the next pclk edge.

Verification
REQ-034 Full 320x240 frame, all pixels 16'hF800 (red), then vsync rise -> res_valid 28 cycles after FE; res_count=76800, res_found=1, res_x=159, res_y=119.
REQ-035 Frame with red only in a 10x10 square at x 100..109, y 50..59, rest 16'h07E0 (green) -> res_count=100, res_x=104, res_y=54, res_found=1.
REQ-036 Frame with 63 red pixels -> res_valid pulses with res_count=63, res_found=0, res_x=0, res_y=0.
REQ-037 Reset released mid-frame with red pixels, then one full all-green frame -> first res_valid reports res_count=0 (partial frame excluded); no earlier pulse.
REQ-038 Second vsync rise 10 cycles after FE -> res_overrun=1, a single res_valid pulse for the first frame, and the second snapshot dropped.
REQ-039 Last red pixel's pix_we one cycle before the vsync rise -> the pixel is counted in that frame.
